// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key-expansion / round datapath.
//   byte_t      : one 8-bit AES state byte
//   AES_WORD_W  : width of an AES column/word (32 bits)
//   SBOX        : FIPS-197 forward S-box, indexed by input byte
//   INV_SBOX    : FIPS-197 inverse S-box, indexed by input byte
// The inverse table only turns into logic where something reads it, which
// happens only when AES_SUB_WORD_INV_EN is defined.
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int AES_WORD_W = 32;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage : aes_pkg

// File: rtl/aes_sub_word_if.sv
// -----------------------------------------------------------------------------
// aes_sub_word_if
// Word-in / word-out bus of the SubWord unit.
//   in_valid  : word_in carries a word to substitute this cycle
//   word_in   : input word, byte lane i = bits [8i+7:8i]
//   inv       : (AES_SUB_WORD_INV_EN only) select the inverse S-box
//   out_valid : word_out holds a fresh result
//   word_out  : registered substituted word
// Modports: master = producer/consumer around the unit, slave = the unit.
// -----------------------------------------------------------------------------
interface aes_sub_word_if #(
  parameter int WORD_W = aes_pkg::AES_WORD_W
);

  logic              in_valid;
  logic [WORD_W-1:0] word_in;
`ifdef AES_SUB_WORD_INV_EN
  logic              inv;
`endif
  logic              out_valid;
  logic [WORD_W-1:0] word_out;

`ifdef AES_SUB_WORD_INV_EN
  modport master (output in_valid, word_in, inv, input out_valid, word_out);
  modport slave  (input in_valid, word_in, inv, output out_valid, word_out);
`else
  modport master (output in_valid, word_in, input out_valid, word_out);
  modport slave  (input in_valid, word_in, output out_valid, word_out);
`endif

endinterface : aes_sub_word_if

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Purely combinational single-byte AES S-box lookup.
//   in_byte  : byte to substitute
//   inv      : 1 = inverse S-box, 0 = forward S-box
//   out_byte : substituted byte
// Without AES_SUB_WORD_INV_EN the inv input is ignored and only the forward
// table is referenced, so no inverse table is built.
// -----------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t in_byte,
  input  logic  inv,
  output byte_t out_byte
);

`ifdef AES_SUB_WORD_INV_EN
  assign out_byte = inv ? INV_SBOX[in_byte] : SBOX[in_byte];
`else
  // Kept on the port so the top can wire every lane the same way.
  logic unused_inv;
  assign unused_inv = inv;
  assign out_byte   = SBOX[in_byte];
`endif

endmodule : aes_sbox

// File: rtl/aes_sub_word.sv
// -----------------------------------------------------------------------------
// aes_sub_word
// Registered AES SubWord: each byte lane of the input word is passed through
// the S-box independently and the result is captured one edge later.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears word_out and out_valid
//   bus   : aes_sub_word_if.slave (in_valid, word_in, [inv], out_valid,
//           word_out)
// Optional: AES_SUB_WORD_INV_EN adds bus.inv to select the inverse S-box,
// sampled together with in_valid.
// word_out only reloads on in_valid; on idle cycles it keeps the last result
// while out_valid drops.
// -----------------------------------------------------------------------------
module aes_sub_word
  import aes_pkg::*;
#(
  parameter int WORD_W    = AES_WORD_W,
  parameter int NUM_BYTES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  aes_sub_word_if.slave bus
);

  logic              inv_sel;
  logic [WORD_W-1:0] sub_word;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;

`ifdef AES_SUB_WORD_INV_EN
  assign inv_sel = bus.inv;
`else
  assign inv_sel = 1'b0;
`endif

  // Lanes are fully independent: one lookup per byte, no cross-lane terms.
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte  (bus.word_in[8*i +: 8]),
      .inv      (inv_sel),
      .out_byte (sub_word[8*i +: 8])
    );
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  // NOTE: word_q is a plain data register, but its reset value is visible on
  // word_out, so it is reset along with the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        word_q <= sub_word;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.word_out  = word_q;

endmodule : aes_sub_word

// File: tb/tb_aes_sub_word.sv
// -----------------------------------------------------------------------------
// tb_aes_sub_word
// Self-checking bench for aes_sub_word. The reference S-box is derived from
// GF(2^8) arithmetic (multiplicative inverse followed by the AES affine map),
// and the inverse table is obtained by inverting that mapping. Covers the
// AES_SUB_WORD_INV_EN build when the macro is defined.
// -----------------------------------------------------------------------------
module tb_aes_sub_word;

  logic clk;
  logic rst_n;

  aes_sub_word_if bus ();

  aes_sub_word dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  ref_fwd [256];
  logic [7:0]  ref_inv [256];
  logic [31:0] exp_word;
  logic        exp_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %08h, expected %08h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] v);
    logic [7:0] inv_v;
    inv_v = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(v, 8'(c)) == 8'h01) inv_v = 8'(c);
    end
    return inv_v ^ rotl(inv_v, 1) ^ rotl(inv_v, 2) ^ rotl(inv_v, 3) ^ rotl(inv_v, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] w, input logic use_inv);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) begin
      r[8*l +: 8] = use_inv ? ref_inv[w[8*l +: 8]] : ref_fwd[w[8*l +: 8]];
    end
    return r;
  endfunction

  // Drive one cycle of input, let one edge pass, compare against the model.
  task automatic step(input string tag, input logic [31:0] w, input logic v, input logic i);
    @(negedge clk);
    bus.in_valid = v;
    bus.word_in  = w;
`ifdef AES_SUB_WORD_INV_EN
    bus.inv      = i;
`endif
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) exp_word = model_word(w, i);
    check({tag, ".word"},  bus.word_out, exp_word);
    check({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, exp_valid});
  endtask

  // Directed step against a fixed result taken from FIPS-197.
  task automatic step_known(input string tag, input logic [31:0] w, input logic i,
                            input logic [31:0] known);
    step(tag, w, 1'b1, i);
    check({tag, ".known"}, bus.word_out, known);
  endtask

  initial begin
    logic [31:0] w;
    logic        v;

    for (int b = 0; b < 256; b++) ref_fwd[b] = model_sbox(8'(b));
    for (int b = 0; b < 256; b++) ref_inv[ref_fwd[b]] = 8'(b);

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.word_in  = '0;
`ifdef AES_SUB_WORD_INV_EN
    bus.inv      = 1'b0;
`endif
    exp_word  = '0;
    exp_valid = 1'b0;

    // Reset state, then release and confirm it holds until the next edge.
    repeat (2) @(posedge clk);
    #1;
    check("rst.word",  bus.word_out, 32'h0);
    check("rst.valid", {31'd0, bus.out_valid}, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.word_in  = 32'hcf4f3c09;
    rst_n        = 1'b1;
    #1;
    check("rel.word",  bus.word_out, 32'h0);
    check("rel.valid", {31'd0, bus.out_valid}, 32'h0);

    // Directed vectors.
    step_known("kv",     32'hcf4f3c09, 1'b0, 32'h8a84eb01);
    step_known("corner", 32'h000153ff, 1'b0, 32'h637ced16);
    step_known("allff",  32'hffffffff, 1'b0, 32'h16161616);
    step_known("b2b0",   32'h00000000, 1'b0, 32'h63636363);
    step_known("b2b1",   32'h01010101, 1'b0, 32'h7c7c7c7c);
    step("idle", 32'h12345678, 1'b0, 1'b0);
    check("idle.hold", bus.word_out, 32'h7c7c7c7c);
    step("idle2", 32'hdeadbeef, 1'b0, 1'b0);

    // Exhaustive sweep of every byte value in each lane, other lanes zero.
    for (int l = 0; l < 4; l++) begin
      for (int b = 0; b < 256; b++) begin
        w = 32'h0;
        w[8*l +: 8] = 8'(b);
        step($sformatf("lane%0d_%02h", l, b), w, 1'b1, 1'b0);
      end
    end

    // Random words with random gaps.
    for (int n = 0; n < 300; n++) begin
      w = $urandom;
      v = ($urandom_range(3) != 0);
      step($sformatf("rnd%0d", n), w, v, 1'b0);
    end

    // Asynchronous reset mid-stream with in_valid still high.
    step("pre_rst", 32'ha5a5a5a5, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.word",  bus.word_out, 32'h0);
    check("mrst.valid", {31'd0, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("mrst_hold.word",  bus.word_out, 32'h0);
    check("mrst_hold.valid", {31'd0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    exp_word     = '0;
    exp_valid    = 1'b0;
    step("post_rst", 32'h01020304, 1'b1, 1'b0);

`ifdef AES_SUB_WORD_INV_EN
    step_known("inv_kv", 32'h637ced16, 1'b1, 32'h000153ff);
    // Round trip: feed S(x) through the inverse path and expect x back.
    for (int n = 0; n < 256; n++) begin
      w = $urandom;
      step($sformatf("rt%0d", n), model_word(w, 1'b0), 1'b1, 1'b1);
      check($sformatf("rt%0d.x", n), bus.word_out, w);
    end
    // Mixed forward/inverse traffic.
    for (int n = 0; n < 64; n++) begin
      step($sformatf("mix%0d", n), $urandom, 1'b1, 1'($urandom_range(1)));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_aes_sub_word

// File: doc/aes_sub_word.md
Name: aes_sub_word

Overview:
- Registered AES SubWord unit. Applies the FIPS-197 forward S-box independently to each of the 4 bytes of a 32-bit word.
- Sits in the execute stage and feeds the key-expansion path: the RotWord output goes in, and SubWord(RotWord(w)) comes out, ready for the Rcon XOR.
- Result is registered with a single-cycle valid pipeline.

Parameters:
- WORD_W, 32, word width in bits; must equal 8*NUM_BYTES.
- NUM_BYTES, 4, number of byte lanes, each substituted independently.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  word_in is valid this cycle.
- word_in  input  WORD_W  word to substitute; byte lane i = bits [8i+7:8i].
- out_valid  output  1  word_out holds a fresh result.
- word_out  output  WORD_W  substituted word, registered.

Behaviour:
- Reset: rst_n low asynchronously forces word_out=0 and out_valid=0. They are held there until the first rising edge after rst_n deasserts.
- Datapath: the next value of each lane i of word_out is SBOX(word_in lane i). The S-box is the FIPS-197 forward table: 256 entries, 8-bit in, 8-bit out, purely combinational.
- Latency: exactly 1 cycle.
  - If in_valid=1 at edge N, then at edge N the output register loads the substituted word and out_valid goes to 1.
  - The result is visible from edge N until the next load.
- If in_valid=0 at an edge:
  - out_valid goes to 0.
  - word_out holds its previous value; it is not cleared.
- Throughput: one word per cycle, back-to-back. No stall or backpressure; the consumer must accept every out_valid pulse.
- Lanes never interact: no carries, no cross-byte dependency. Every possible byte value maps to a defined output; there are no X/invalid codes.
- Reset asserted mid-stream drops any in-flight result: out_valid=0 immediately and asynchronously.
- No internal state beyond the output word and valid registers.

Optional Feature:
- Macro AES_SUB_WORD_INV_EN.
- When defined:
  - Adds input port inv (1 bit), sampled with in_valid.
  - inv=1 selects the FIPS-197 inverse S-box for all lanes; inv=0 selects the forward S-box.
  - Latency and reset behaviour are unchanged.
- When undefined:
  - No inv port, forward S-box only, no inverse table synthesized.

Decomposition:
- Shared package aes_pkg holds:
  - byte_t (8-bit logic).
  - Constant AES_WORD_W=32.
  - Forward table SBOX[256] and inverse table INV_SBOX[256] as localparam arrays.
- One sub-module, aes_sbox: a combinational 8-bit lookup with an inv input (tied 0 when the macro is off).
- aes_sub_word instantiates NUM_BYTES copies of aes_sbox via a generate loop, plus the output registers.

Test Plan:
- Reset: drive rst_n=0 mid-simulation with in_valid=1 -> word_out=0x00000000 and out_valid=0 immediately, without waiting for a clock edge.
- Known vector: in_valid=1, word_in=0xCF4F3C09 -> one edge later word_out=0x8A84EB01, out_valid=1.
- Corner bytes: word_in=0x000153FF -> word_out=0x637CED16. Also word_in=0xFFFFFFFF -> 0x16161616.
- Back-to-back and idle:
  - Consecutive valid inputs 0x00000000 then 0x01010101 -> 0x63636363 then 0x7C7C7C7C on successive cycles, out_valid high both cycles.
  - Then in_valid=0 -> out_valid=0 and word_out stays 0x7C7C7C7C.
- Exhaustive lane check: sweep byte b over 0x00–0xFF in each lane (other lanes 0x00) -> that lane equals the FIPS-197 S(b) and the other lanes equal 0x63.
- With AES_SUB_WORD_INV_EN: inv=1, word_in=0x637CED16 -> word_out=0x000153FF. Also check the round trip INV(S(x))=x over a sweep of 256 words.
